// File: rtl/key_priority_encoder_pkg.sv
// key_enc_pkg: default sizing constants, FSM state type and the priority-encode helper
// shared by the encoder and its bench model.
package key_enc_pkg;
    localparam int N_IN_DEFAULT = 8;
    localparam int STABLE_DEFAULT = 4;
    localparam int MAX_N = 64;
    localparam int MAX_IDX_W = 6;

    typedef enum logic {IDLE, PEND} evt_state_t;

    typedef struct packed {
        logic                 any;
        logic [MAX_IDX_W-1:0] idx;
        logic                 multi;
    } cand_t;

    function automatic cand_t prio_enc(input logic [MAX_N-1:0] v, input logic high);
        cand_t c;
        int    n;
        c = '0;
        n = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (v[i]) begin
                n++;
                if (high || n == 1) c.idx = MAX_IDX_W'(i);
            end
        end
        c.any = n != 0;
        c.multi = n > 1;
        return c;
    endfunction
endpackage

// File: rtl/key_priority_encoder_if.sv
// key_priority_encoder_if: press-event valid/ready channel towards the tone logic.
interface key_priority_encoder_if #(parameter int IDX_W = 3);
    logic             evt_valid;
    logic [IDX_W-1:0] evt_code;
    logic             evt_ready;
    logic             evt_overrun;

    modport master(output evt_valid, evt_code, evt_overrun, input evt_ready);
    modport slave(input evt_valid, evt_code, evt_overrun, output evt_ready);
endinterface

// File: rtl/key_priority_encoder_sync_2ff.sv
// sync_2ff: two-flop synchroniser bringing the raw key vector into the clk domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/key_priority_encoder.sv
// key_priority_encoder: synchronise, priority-encode and debounce a key vector, then
// deliver each new press as a registered valid/ready event.
module key_priority_encoder
    import key_enc_pkg::*;
#(
    parameter int N_IN          = N_IN_DEFAULT,
    parameter int IDX_W         = $clog2(N_IN),
    parameter int STABLE_CYCLES = STABLE_DEFAULT,
    parameter int PRIO_HIGH     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [N_IN-1:0]       data_in,
    output logic [IDX_W-1:0]      code,
    output logic                  code_valid,
    output logic                  multi_hot,
    key_priority_encoder_if.master evt
);
    localparam int CW = IDX_W + 2;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

    logic [N_IN-1:0]      s2;
    cand_t                enc;
    logic [MAX_IDX_W-1:0] idx_unused;
    logic [CW-1:0]        cand, prev_cand, committed;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 commit, press, ovr_nxt;
    evt_state_t           state, state_nxt;
    logic [IDX_W-1:0]     evt_code_q;
    logic                 evt_overrun_q;

    sync_2ff #(.WIDTH(N_IN)) u_sync (.clk(clk), .rst_n(rst_n), .d(data_in), .q(s2));

    assign enc        = prio_enc(MAX_N'(s2), PRIO_HIGH != 0);
    assign idx_unused = enc.idx;
    assign cand       = {enc.any, enc.idx[IDX_W-1:0], enc.multi};
    assign committed  = {code_valid, code, multi_hot};

    // Run length of the current candidate; a change restarts the run at 1.
    assign cnt_nxt = !enable ? '0 :
                     cand != prev_cand ? CNT_W'(1) :
                     cnt == STABLE_CNT ? cnt : cnt + 1'b1;
    assign commit  = enable && cand == prev_cand && cnt_nxt == STABLE_CNT && cand != committed;
    // Releases and multi_hot-only changes commit without raising an event.
    assign press   = commit && enc.any && (!code_valid || enc.idx[IDX_W-1:0] != code);

    always_comb begin
        state_nxt = state;
        ovr_nxt   = 1'b0;
        if (press) begin
            state_nxt = PEND;
            ovr_nxt   = state == PEND && !evt.evt_ready;
        end else if (state == PEND && evt.evt_ready) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_cand     <= '0;
            cnt           <= '0;
            code_valid    <= 1'b0;
            code          <= '0;
            multi_hot     <= 1'b0;
            state         <= IDLE;
            evt_code_q    <= '0;
            evt_overrun_q <= 1'b0;
        end else begin
            prev_cand     <= cand;
            cnt           <= cnt_nxt;
            if (commit) {code_valid, code, multi_hot} <= cand;
            state         <= state_nxt;
            if (press) evt_code_q <= enc.idx[IDX_W-1:0];
            evt_overrun_q <= ovr_nxt;
        end
    end

    assign evt.evt_valid   = state == PEND;
    assign evt.evt_code    = evt_code_q;
    assign evt.evt_overrun = evt_overrun_q;
endmodule

// File: tb/tb_key_priority_encoder.sv
// tb_key_priority_encoder: directed vector table plus randomized run against a
// history-based reference model of the debounce/commit/event rules.
module tb_key_priority_encoder;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  data_in = '0;
    logic [11:0] data12 = '0;
    logic [2:0]  code, code_hi;
    logic [3:0]  code12;
    logic        code_valid, multi_hot, valid_hi, multi_hi, valid12, multi12;
    logic [9:0]  dut_out;

    key_priority_encoder_if #(.IDX_W(3)) bus ();
    key_priority_encoder_if #(.IDX_W(3)) bus_hi ();
    key_priority_encoder_if #(.IDX_W(4)) bus12 ();
    assign bus_hi.evt_ready = 1'b0;
    assign bus12.evt_ready  = 1'b0;

    key_priority_encoder dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .data_in(data_in),
        .code(code), .code_valid(code_valid), .multi_hot(multi_hot), .evt(bus));
    key_priority_encoder #(.PRIO_HIGH(1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .enable(enable), .data_in(data_in),
        .code(code_hi), .code_valid(valid_hi), .multi_hot(multi_hi), .evt(bus_hi));
    key_priority_encoder #(.N_IN(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .data_in(data12),
        .code(code12), .code_valid(valid12), .multi_hot(multi12), .evt(bus12));

    always #5 clk = ~clk;

    assign dut_out = {code_valid, code, multi_hot, bus.evt_valid, bus.evt_code, bus.evt_overrun};

    int checks = 0, errors = 0, ovr_seen = 0;

    // Model state: synchroniser image, per-edge candidate/enable history, committed
    // candidate (0 = none, else 1 + 2*idx + multi) and the pending event.
    logic [7:0] m_s1, m_s2;
    int         ch[$];
    bit         eh[$];
    int         mc, m_ec;
    bit         m_pend, m_ovr;

    typedef struct {
        logic [7:0] d;
        logic       en;
        logic       rdy;
        int         n;
        logic [8:0] exp;
        int         ovr;
        int         hi;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int cand_of(input logic [7:0] v);
        int lo;
        lo = -1;
        for (int i = 7; i >= 0; i--) if (v[i]) lo = i;
        return lo < 0 ? 0 : 1 + 2 * lo + ($countones(v) > 1 ? 1 : 0);
    endfunction

    function automatic logic [9:0] model_out();
        logic [2:0] cc;
        cc = mc == 0 ? 3'd0 : 3'((mc - 1) / 2);
        return {mc != 0, cc, mc != 0 && (mc - 1) % 2 == 1, m_pend, 3'(m_ec), m_ovr};
    endfunction

    function automatic logic [8:0] pk(input logic v, input int c, input logic m,
                                      input logic ev, input int ec);
        return {v, 3'(c), m, ev, 3'(ec)};
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0;
        ch.delete(); eh.delete();
        mc = 0; m_ec = 0; m_pend = 0; m_ovr = 0;
    endtask

    task automatic step(input logic [7:0] d, input logic en, input logic rdy);
        int c, prevc, n;
        bit commit, press;
        data_in = d; enable = en; bus.evt_ready = rdy;
        c = cand_of(m_s2);
        prevc = ch.size() > 0 ? ch[$] : 0;
        ch.push_back(c);
        eh.push_back(en);
        n = 0;
        for (int i = ch.size() - 1; i >= 0 && n < STABLE; i--) begin
            if (!eh[i] || ch[i] != c) break;
            n++;
        end
        commit = en && c == prevc && n == STABLE && c != mc;
        press  = commit && c != 0 && (mc == 0 || (c - 1) / 2 != (mc - 1) / 2);
        m_ovr  = press && m_pend && !rdy;
        if (press) begin
            m_pend = 1;
            m_ec = (c - 1) / 2;
        end else if (rdy) begin
            m_pend = 0;
        end
        if (commit) mc = c;
        m_s2 = m_s1;
        m_s1 = d;
        @(posedge clk);
        #1;
        if (bus.evt_overrun) ovr_seen++;
        check("model", dut_out, model_out());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        vec_t tv[$];
        logic [7:0] d;
        int len;
        tv.push_back(vec_t'{8'h04, 1'b1, 1'b0, 5, pk(0, 0, 0, 0, 0), 0, -1});
        tv.push_back(vec_t'{8'h04, 1'b1, 1'b0, 1, pk(1, 2, 0, 1, 2), 0, -1});
        tv.push_back(vec_t'{8'h04, 1'b1, 1'b1, 1, pk(1, 2, 0, 0, 2), 0, -1});
        tv.push_back(vec_t'{8'h90, 1'b1, 1'b0, 6, pk(1, 4, 1, 1, 4), 0, 15});
        tv.push_back(vec_t'{8'h90, 1'b1, 1'b1, 1, pk(1, 4, 1, 0, 4), 0, 15});
        tv.push_back(vec_t'{8'h00, 1'b1, 1'b0, 6, pk(0, 0, 0, 0, 4), 0, -1});
        tv.push_back(vec_t'{8'h01, 1'b1, 1'b0, 3, pk(0, 0, 0, 0, 4), 0, -1});
        tv.push_back(vec_t'{8'h00, 1'b1, 1'b0, 8, pk(0, 0, 0, 0, 4), 0, -1});
        tv.push_back(vec_t'{8'h04, 1'b1, 1'b0, 6, pk(1, 2, 0, 1, 2), 0, -1});
        tv.push_back(vec_t'{8'h20, 1'b1, 1'b0, 6, pk(1, 5, 0, 1, 5), 1, -1});
        tv.push_back(vec_t'{8'h20, 1'b1, 1'b1, 1, pk(1, 5, 0, 0, 5), 0, -1});
        tv.push_back(vec_t'{8'h40, 1'b0, 1'b0, 8, pk(1, 5, 0, 0, 5), 0, -1});
        tv.push_back(vec_t'{8'h40, 1'b1, 1'b0, 3, pk(1, 5, 0, 0, 5), 0, -1});
        tv.push_back(vec_t'{8'h40, 1'b1, 1'b0, 1, pk(1, 6, 0, 1, 6), 0, -1});
        tv.push_back(vec_t'{8'h00, 1'b1, 1'b0, 6, pk(0, 0, 0, 1, 6), 0, -1});
        tv.push_back(vec_t'{8'h00, 1'b1, 1'b1, 1, pk(0, 0, 0, 0, 6), 0, -1});

        bus.evt_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", dut_out, 10'd0);
        @(negedge clk);
        rst_n = 1'b1;
        data12 = 12'h800;

        foreach (tv[i]) begin
            ovr_seen = 0;
            for (int k = 0; k < tv[i].n; k++) step(tv[i].d, tv[i].en, tv[i].rdy);
            check($sformatf("vec%0d", i), 32'(dut_out[9:1]), 32'(tv[i].exp));
            check($sformatf("vec%0d_overruns", i), ovr_seen, tv[i].ovr);
            if (tv[i].hi >= 0) check($sformatf("vec%0d_prio_high", i), {multi_hi, code_hi}, tv[i].hi);
        end
        check("n12_bit11", {valid12, code12}, 5'b1_1011);

        repeat (60) begin
            case ($urandom_range(0, 2))
                0: d = 8'h00;
                1: d = 8'(1 << $urandom_range(0, 7));
                default: d = 8'($urandom);
            endcase
            len = $urandom_range(1, 7);
            repeat (len) step(d, $urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0);
        end

        repeat (6) step(8'h00, 1'b1, 1'b1);
        repeat (6) step(8'h08, 1'b1, 1'b0);
        check("pend_before_reset", {bus.evt_valid, bus.evt_code}, 4'b1011);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_out, 10'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) step(8'h08, 1'b1, 1'b0);
        check("press_after_reset", {bus.evt_valid, bus.evt_code}, 4'b1011);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
